bram_sdp_hs: RTL and testbench
==============================

Name: bram_sdp_hs

Overview:
- Parametrised simple-dual-port (1W/1R) block RAM replacing the fixed 2K x 8 data RAM.
- Adds:
  - configurable word width and depth
  - per-byte write enables
  - valid/ready read handshake with output hold under backpressure
  - a post-reset zero-fill sequencer
- Sits between the core LSU/bus adapter and on-chip data storage.
- Maps to FPGA block RAM: one synchronous read and one synchronous write port per cycle.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8, minimum 8.
- DEPTH, 1024, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  input  1  clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_we  input  1  write request.
- i_wbe  input  DATA_W/8  byte enables; bit k covers i_wdata[8k+7:8k].
- i_waddr  input  ADDR_W  write word address.
- i_wdata  input  DATA_W  write data.
- o_wready  output  1  write port accepting; high only when init done.
- i_rreq  input  1  read request valid.
- i_raddr  input  ADDR_W  read word address.
- o_rreq_ready  output  1  read request accepted this cycle if i_rreq high.
- o_rvalid  output  1  read data valid.
- i_rready  input  1  consumer takes o_rdata this cycle.
- o_rdata  output  DATA_W  read data.
- o_init_done  output  1  zero-fill complete.

Behaviour:
- Reset (async assert, sync release):
  - o_rvalid=0, o_rdata=0, o_init_done=0, o_wready=0, o_rreq_ready=0.
  - Sequencer enters CLEAR with fill pointer = 0.
- State machine: CLEAR -> RUN.
  - CLEAR: writes all-zero to address ptr each cycle, ptr increments; external writes and reads are not accepted.
  - CLEAR lasts exactly DEPTH cycles. The cycle after the write to DEPTH-1, state = RUN and o_init_done=1 (first RUN cycle = DEPTH+1 cycles after reset release).
  - RUN is terminal until rst. rst asserted mid-CLEAR restarts fill from address 0.
- Write (RUN):
  - o_wready=1.
  - When i_we=1, only bytes with i_wbe[k]=1 are updated; i_wbe=0 is a no-op.
  - No write latency visible to later reads: a read accepted in the next cycle returns the new data.
- Read handshake:
  - o_rreq_ready = o_init_done & (!o_rvalid | i_rready).
  - Accept = i_rreq & o_rreq_ready. On accept, mem[i_raddr] is sampled and presented next cycle with o_rvalid=1 (latency 1).
  - While o_rvalid=1 and i_rready=0, o_rdata and o_rvalid hold stable; the RAM is not re-read.
  - o_rvalid drops after i_rready=1 with no new accept in that cycle.
  - Back-to-back accepts with i_rready held high give one word per cycle.
- Out-of-range (addr >= DEPTH):
  - Writes are dropped.
  - Reads are accepted and return all-zero.
- Simultaneous read accept and write to the same address: behaviour set by the optional feature.
- Writes to different addresses in the same cycle as a read have no interaction.

Optional Feature:
- Macro: BRAM_SDP_WR_FWD_EN.
- Defined:
  - Same-cycle same-address read returns the merged word: bytes with i_wbe=1 from i_wdata, others from the old contents (write-first).
  - Implemented as a bypass mux on the output register.
- Undefined:
  - Same-cycle same-address read returns the old contents (read-first), with no bypass logic.
  - The write still lands.

Test Plan:
- Init fill:
  - Preload junk via backdoor; release rst.
  - o_init_done rises exactly DEPTH+1 cycles later.
  - Reads of addr 0, DEPTH/2 and DEPTH-1 return 0x00000000.
  - Reads issued during CLEAR see o_rreq_ready=0.
- Byte enables:
  - Write 0xAABBCCDD to addr 5 with wbe=4'b1111, then 0x11223344 with wbe=4'b0101.
  - Read addr 5 returns 0xAA22CC44 one cycle after accept.
- Backpressure:
  - Read addr 5 with i_rready=0 for 4 cycles: o_rvalid=1, o_rdata stable, o_rreq_ready=0 throughout.
  - Raise i_rready with a new request to addr 6 pending: addr 6 is accepted that cycle and its data appears next cycle.
- Read-during-write:
  - addr 7 holds 0x01020304; in the same cycle write 0xFFFFFFFF with wbe=4'b0011 and read addr 7.
  - With BRAM_SDP_WR_FWD_EN: returns 0x0102FFFF. Without: returns 0x01020304.
  - In both cases a following read returns 0x0102FFFF.
- Reset mid-operation:
  - Assert rst at fill ptr=100 and release: fill restarts at 0 with the full DEPTH+1 latency.
  - Assert rst while o_rvalid=1: o_rvalid=0 and o_rdata=0 immediately, without waiting for a clock.
- Out-of-range, DEPTH=1000:
  - Write 0xDEADBEEF to addr 1000 (ignored).
  - Read addr 1000 returns 0; read addr 999 returns unchanged contents.

Source files
------------

// File: rtl/bram_sdp_hs.sv
// ---------------------------------------------------------------------------------------------
// bram_sdp_hs: parametrised simple-dual-port (1W/1R) block RAM with byte write enables, a
// valid/ready read handshake that holds its output under backpressure, and a zero-fill
// sequencer that clears every word after reset before the ports open.
//
// Optional feature macro: BRAM_SDP_WR_FWD_EN
//   defined   : a read accepted in the same cycle as a write to the same address returns the
//               merged word (write-first), via a bypass mux in front of the output register.
//   undefined : the same collision returns the old contents (read-first); no bypass logic.
//
// Parameters
//   DATA_W  word width in bits (multiple of 8, minimum 8)
//   DEPTH   number of words (any value, need not be a power of two)
//   ADDR_W  address width, derived from DEPTH
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   i_we           write request
//   i_wbe          byte enables, bit k covers i_wdata[8k+7:8k]
//   i_waddr        write word address
//   i_wdata        write data
//   o_wready       write port accepting (high once zero-fill is done)
//   i_rreq         read request valid
//   i_raddr        read word address
//   o_rreq_ready   read request accepted this cycle when i_rreq is high
//   o_rvalid       read data valid
//   i_rready       consumer takes o_rdata this cycle
//   o_rdata        read data
//   o_init_done    zero-fill complete
// ---------------------------------------------------------------------------------------------
module bram_sdp_hs #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_we,
   input  logic [DATA_W/8-1:0] i_wbe,
   input  logic [ADDR_W-1:0]   i_waddr,
   input  logic [DATA_W-1:0]   i_wdata,
   output logic                o_wready,
   input  logic                i_rreq,
   input  logic [ADDR_W-1:0]   i_raddr,
   output logic                o_rreq_ready,
   output logic                o_rvalid,
   input  logic                i_rready,
   output logic [DATA_W-1:0]   o_rdata,
   output logic                o_init_done
);

   localparam int unsigned NBYTES = DATA_W / 8;

   // StRelease is the synchronous-release stage: one cycle after rst drops before the
   // first clear write, so the fill never starts on a partially released edge.
   typedef enum logic [1:0] {
      StRelease,
      StClear,
      StRun
   } state_e;

   state_e              r_state;
   logic [ADDR_W-1:0]   r_ptr;
   logic                r_init_done;
   logic                r_wready;
   logic                r_rvalid;
   logic [DATA_W-1:0]   r_rdata;

   // Storage: no reset, so it maps onto block RAM.
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_waddr_ok;
   logic                w_raddr_ok;
   logic                w_ptr_last;
   logic                w_clear;
   logic                w_ext_we;
   logic                w_rreq_ready;
   logic                w_accept;

   logic                w_mem_we;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [NBYTES-1:0]   w_mem_be;
   logic [DATA_W-1:0]   w_mem_wdata;
   logic [DATA_W-1:0]   w_rd_word;

   // Range checks are done at 32 bits so DEPTH == 2**ADDR_W does not wrap to zero.
   assign w_waddr_ok   = (32'(i_waddr) < DEPTH);
   assign w_raddr_ok   = (32'(i_raddr) < DEPTH);
   assign w_ptr_last   = (32'(r_ptr) == DEPTH - 1);
   assign w_clear      = (r_state == StClear);

   // r_wready is only set in StRun, so it also gates external writes during the fill.
   assign w_ext_we     = r_wready & i_we & w_waddr_ok;
   assign w_rreq_ready = r_init_done & (~r_rvalid | i_rready);
   assign w_accept     = i_rreq & w_rreq_ready;

   // ------------------------------------------------------------------------------------------
   // Write port mux: the fill sequencer owns the write port until it finishes.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      w_mem_we    = w_clear | w_ext_we;
      w_mem_addr  = i_waddr;
      w_mem_be    = i_wbe;
      w_mem_wdata = i_wdata;
      if (w_clear) begin
         w_mem_addr  = r_ptr;
         w_mem_be    = '1;
         w_mem_wdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int k = 0; k < int'(NBYTES); k++) begin
            if (w_mem_be[k]) begin
               r_mem[w_mem_addr][8*k +: 8] <= w_mem_wdata[8*k +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------------------------------
   // Read word selection. Out-of-range addresses read as zero.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      w_rd_word = '0;
      if (w_raddr_ok) begin
         w_rd_word = r_mem[i_raddr];
      end
`ifdef BRAM_SDP_WR_FWD_EN
      // Write-first bypass: enabled bytes of a same-cycle write to the same word win.
      if (w_raddr_ok && w_ext_we && (i_waddr == i_raddr)) begin
         for (int k = 0; k < int'(NBYTES); k++) begin
            if (i_wbe[k]) begin
               w_rd_word[8*k +: 8] = i_wdata[8*k +: 8];
            end
         end
      end
`endif
   end

   // ------------------------------------------------------------------------------------------
   // Output register. Under backpressure (valid && !ready) nothing is accepted, so data and
   // valid hold and the RAM is not re-read.
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else if (w_accept) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_word;
      end else if (i_rready) begin
         r_rvalid <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Zero-fill sequencer: release -> clear DEPTH words -> run (terminal until rst).
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StRelease;
         r_ptr       <= '0;
         r_init_done <= 1'b0;
         r_wready    <= 1'b0;
      end else begin
         unique case (r_state)
            StRelease: begin
               r_state <= StClear;
            end
            StClear: begin
               if (w_ptr_last) begin
                  r_state     <= StRun;
                  r_init_done <= 1'b1;
                  r_wready    <= 1'b1;
               end else begin
                  r_ptr <= r_ptr + ADDR_W'(1);
               end
            end
            StRun: begin
               r_state <= StRun;
            end
            default: begin
               r_state <= StRelease;
            end
         endcase
      end
   end

   assign o_wready     = r_wready;
   assign o_rreq_ready = w_rreq_ready;
   assign o_rvalid     = r_rvalid;
   assign o_rdata      = r_rdata;
   assign o_init_done  = r_init_done;

endmodule

// File: tb/tb_bram_sdp_hs.sv
// ---------------------------------------------------------------------------------------------
// tb_bram_sdp_hs: self-checking bench for bram_sdp_hs (DATA_W=32, DEPTH=1000).
// Directed table vectors, hand-written reset/backpressure sequences, then random traffic
// checked against an array-based reference model of the memory and handshake.
// ---------------------------------------------------------------------------------------------
module tb_bram_sdp_hs;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 1000;
   localparam int unsigned ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_we = 1'b0;
   logic [3:0]        i_wbe = '0;
   logic [ADDR_W-1:0] i_waddr = '0;
   logic [31:0]       i_wdata = '0;
   logic              o_wready;
   logic              i_rreq = 1'b0;
   logic [ADDR_W-1:0] i_raddr = '0;
   logic              o_rreq_ready;
   logic              o_rvalid;
   logic              i_rready = 1'b0;
   logic [31:0]       o_rdata;
   logic              o_init_done;

   bram_sdp_hs #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_we         (i_we),
      .i_wbe        (i_wbe),
      .i_waddr      (i_waddr),
      .i_wdata      (i_wdata),
      .o_wready     (o_wready),
      .i_rreq       (i_rreq),
      .i_raddr      (i_raddr),
      .o_rreq_ready (o_rreq_ready),
      .o_rvalid     (o_rvalid),
      .i_rready     (i_rready),
      .o_rdata      (o_rdata),
      .o_init_done  (o_init_done)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model state
   logic [31:0] m_mem [DEPTH];
   logic        m_done  = 1'b0;
   logic        m_valid = 1'b0;
   logic [31:0] m_data  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] raddr, input logic we,
                                          input logic [3:0] wbe, input logic [ADDR_W-1:0] waddr,
                                          input logic [31:0] wdata);
      logic [31:0] r;
      if (32'(raddr) >= DEPTH) return 32'h0;
      r = m_mem[raddr];
`ifdef BRAM_SDP_WR_FWD_EN
      if (we && m_done && (waddr == raddr)) r = merge(r, wdata, wbe);
`else
      if (we && wbe == 4'hF && waddr == raddr && 1'b0) r = wdata;
`endif
      return r;
   endfunction

   // One clock cycle: called at a negedge, drives inputs, checks, returns at the next negedge.
   task automatic cycle(input logic we, input logic [3:0] wbe, input logic [ADDR_W-1:0] waddr,
                        input logic [31:0] wdata, input logic rreq,
                        input logic [ADDR_W-1:0] raddr, input logic rready);
      logic        ready;
      logic        acc;
      logic [31:0] rd;
      i_we = we; i_wbe = wbe; i_waddr = waddr; i_wdata = wdata;
      i_rreq = rreq; i_raddr = raddr; i_rready = rready;
      #1;
      ready = m_done && (!m_valid || rready);
      check("rreq_ready", 32'(o_rreq_ready), 32'(ready));
      check("wready", 32'(o_wready), 32'(m_done));
      acc = rreq && ready;
      rd  = m_read(raddr, we, wbe, waddr, wdata);
      @(posedge clk);
      if (acc) begin
         m_valid = 1'b1;
         m_data  = rd;
      end else if (rready) begin
         m_valid = 1'b0;
      end
      if (we && m_done && 32'(waddr) < DEPTH) m_mem[waddr] = merge(m_mem[waddr], wdata, wbe);
      #1;
      check("rvalid", 32'(o_rvalid), 32'(m_valid));
      if (m_valid) check("rdata", o_rdata, m_data);
      @(negedge clk);
   endtask

   // Releases rst at a negedge and measures edges until o_init_done rises.
   task automatic wait_init();
      int n;
      n = 0;
      i_we = 1'b0; i_rreq = 1'b1; i_raddr = '0; i_rready = 1'b1;
      m_done = 1'b0; m_valid = 1'b0;
      rst = 1'b0;
      while (n < 3 * int'(DEPTH)) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1 || n == int'(DEPTH)) begin
            check("clear_rreq_ready", 32'(o_rreq_ready), 32'h0);
            check("clear_wready", 32'(o_wready), 32'h0);
            check("clear_rvalid", 32'(o_rvalid), 32'h0);
         end
         if (o_init_done) break;
      end
      check("init_latency", 32'(n), 32'(DEPTH + 1));
      i_rreq = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 32'h0;
      m_done = 1'b1;
      m_valid = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      logic              we;
      logic [3:0]        wbe;
      logic [ADDR_W-1:0] waddr;
      logic [31:0]       wdata;
      logic              rreq;
      logic [ADDR_W-1:0] raddr;
      logic              rready;
      logic              exp_valid;
      logic [31:0]       exp_data;
   } vec_t;

   vec_t tab[12];

   initial begin
      logic [31:0] rdw_exp;
`ifdef BRAM_SDP_WR_FWD_EN
      rdw_exp = 32'h0102FFFF;
`else
      rdw_exp = 32'h01020304;
`endif
      tab[0]  = '{1, 4'hF, 10'd5,    32'hAABBCCDD, 0, 10'd0,    1, 0, 32'h0};
      tab[1]  = '{1, 4'h5, 10'd5,    32'h11223344, 0, 10'd0,    1, 0, 32'h0};
      tab[2]  = '{1, 4'hF, 10'd6,    32'h66666666, 1, 10'd5,    1, 1, 32'hAA22CC44};
      tab[3]  = '{1, 4'hF, 10'd7,    32'h01020304, 0, 10'd0,    1, 0, 32'h0};
      tab[4]  = '{1, 4'h3, 10'd7,    32'hFFFFFFFF, 1, 10'd7,    1, 1, rdw_exp};
      tab[5]  = '{0, 4'h0, 10'd0,    32'h0,        1, 10'd7,    1, 1, 32'h0102FFFF};
      tab[6]  = '{1, 4'hF, 10'd999,  32'h12345678, 0, 10'd0,    1, 0, 32'h0};
      tab[7]  = '{1, 4'hF, 10'd1000, 32'hDEADBEEF, 1, 10'd6,    1, 1, 32'h66666666};
      tab[8]  = '{0, 4'h0, 10'd0,    32'h0,        1, 10'd1000, 1, 1, 32'h0};
      tab[9]  = '{0, 4'h0, 10'd0,    32'h0,        1, 10'd999,  1, 1, 32'h12345678};
      tab[10] = '{1, 4'h0, 10'd5,    32'hFFFFFFFF, 0, 10'd0,    1, 0, 32'h0};
      tab[11] = '{0, 4'h0, 10'd0,    32'h0,        1, 10'd5,    1, 1, 32'hAA22CC44};

      // Reset state
      #22;
      @(negedge clk);
      check("rst_rvalid", 32'(o_rvalid), 32'h0);
      check("rst_rdata", o_rdata, 32'h0);
      check("rst_init_done", 32'(o_init_done), 32'h0);
      check("rst_wready", 32'(o_wready), 32'h0);
      check("rst_rreq_ready", 32'(o_rreq_ready), 32'h0);

      // Reset mid-fill at ptr ~100, then full fill
      rst = 1'b0;
      repeat (101) @(posedge clk);
      #2 rst = 1'b1;
      #1 check("midfill_rst_done", 32'(o_init_done), 32'h0);
      @(negedge clk);
      wait_init();

      // Directed table
      foreach (tab[i]) begin
         cycle(tab[i].we, tab[i].wbe, tab[i].waddr, tab[i].wdata, tab[i].rreq, tab[i].raddr,
               tab[i].rready);
         check("tab_rvalid", 32'(o_rvalid), 32'(tab[i].exp_valid));
         if (tab[i].exp_valid) check("tab_rdata", o_rdata, tab[i].exp_data);
      end

      // Backpressure: hold addr 5 for 4 cycles with addr 6 pending
      cycle(0, 4'h0, 10'd0, 32'h0, 0, 10'd0, 1);
      cycle(0, 4'h0, 10'd0, 32'h0, 1, 10'd5, 0);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 4'h0, 10'd0, 32'h0, 1, 10'd6, 0);
         check("bp_rvalid", 32'(o_rvalid), 32'h1);
         check("bp_rdata", o_rdata, 32'hAA22CC44);
         check("bp_rreq_ready", 32'(o_rreq_ready), 32'h0);
      end
      cycle(0, 4'h0, 10'd0, 32'h0, 1, 10'd6, 1);
      check("bp_release_data", o_rdata, 32'h66666666);
      cycle(0, 4'h0, 10'd0, 32'h0, 0, 10'd0, 1);
      check("bp_drop_rvalid", 32'(o_rvalid), 32'h0);

      // Junk, then reset while o_rvalid=1, then refill must clear it
      cycle(1, 4'hF, 10'd0,   32'hA5A5A5A5, 0, 10'd0, 1);
      cycle(1, 4'hF, 10'd500, 32'h5A5A5A5A, 0, 10'd0, 1);
      cycle(1, 4'hF, 10'd999, 32'hC3C3C3C3, 0, 10'd0, 1);
      cycle(0, 4'h0, 10'd0,   32'h0,        1, 10'd0, 0);
      check("pre_rst_rdata", o_rdata, 32'hA5A5A5A5);
      #2 rst = 1'b1;
      #1;
      check("async_rst_rvalid", 32'(o_rvalid), 32'h0);
      check("async_rst_rdata", o_rdata, 32'h0);
      check("async_rst_done", 32'(o_init_done), 32'h0);
      @(negedge clk);
      wait_init();
      cycle(0, 4'h0, 10'd0, 32'h0, 1, 10'd0, 1);
      check("zero_addr0", o_rdata, 32'h0);
      cycle(0, 4'h0, 10'd0, 32'h0, 1, 10'd500, 1);
      check("zero_addr500", o_rdata, 32'h0);
      cycle(0, 4'h0, 10'd0, 32'h0, 1, 10'd999, 1);
      check("zero_addr999", o_rdata, 32'h0);

      // Random traffic on a small address window plus the out-of-range edge
      for (int i = 0; i < 3000; i++) begin
         logic [ADDR_W-1:0] wa;
         logic [ADDR_W-1:0] ra;
         wa = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(995, 1003))
                                          : ADDR_W'($urandom_range(0, 15));
         ra = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(995, 1003))
                                          : ADDR_W'($urandom_range(0, 15));
         cycle(1'($urandom_range(0, 1)), 4'($urandom), wa, $urandom,
               1'($urandom_range(0, 9) < 7), ra, 1'($urandom_range(0, 9) < 6));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
